// File: rtl/router_pkg.sv
// Shared constants, header field helpers and FSM state encoding for the 1x3 packet router.
package router_pkg;
    localparam int NUM_PORTS = 3;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 2;
    localparam int LEN_MSB   = 7;
    localparam int LEN_LSB   = 2;
    localparam int ADDR_MSB  = 1;
    localparam int LEN_W     = LEN_MSB - LEN_LSB + 1;

    localparam logic [ADDR_W-1:0] DROP_ADDR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_PARITY  = 2'd2,
        ST_DROP    = 2'd3
    } state_e;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W-1:0] hdr);
        return hdr[ADDR_MSB:0];
    endfunction
endpackage

// File: rtl/router_if.sv
// Byte-stream input and three-port output bundle of the router; master = driver/sink side, slave = router.
interface router_if;
    import router_pkg::*;

    logic [DATA_W-1:0]           in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [NUM_PORTS*DATA_W-1:0] out_data;
    logic [NUM_PORTS-1:0]        out_valid;
    logic [NUM_PORTS-1:0]        out_ready;
    logic                        parity_err;
    logic                        addr_err;
    logic [NUM_PORTS-1:0]        timeout_flush;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, parity_err, addr_err, timeout_flush
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, parity_err, addr_err, timeout_flush
    );
endinterface

// File: rtl/router_fifo.sv
// First-word-fall-through FIFO with push/pop/flush; the head entry is always visible on dout_o.
module router_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    // A flush discards any write landing in the same cycle.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/router_1x3.sv
// 1x3 packet router: parses {len,addr} headers and steers whole packets into per-port FIFOs.
// Optional stall-timeout flush of each output FIFO is enabled with ROUTER_TIMEOUT_EN.
module router_1x3
    import router_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic     clk,
    input  logic     rst,
    router_if.slave  bus
);
    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  par_q, par_d;
    logic               parity_err_q, parity_err_d;
    logic               addr_err_q, addr_err_d;

    logic [NUM_PORTS-1:0] full, empty, push, pop, flush;
    logic [ADDR_W-1:0]    hdr_a;
    logic [ADDR_W-1:0]    dest;
    logic                 dest_full;
    logic                 in_ready_c;
    logic                 accept;
    logic                 write_en;

    assign hdr_a = hdr_addr(bus.in_data);
    // In IDLE the byte on the bus is the header, so its own addr field picks the target FIFO.
    assign dest  = (state_q == ST_IDLE) ? hdr_a : addr_q;

    always_comb begin
        dest_full = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (dest == ADDR_W'(i)) dest_full = full[i];
        end
    end

    always_comb begin
        in_ready_c = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE:    in_ready_c = (hdr_a == DROP_ADDR) || !dest_full;
                ST_PAYLOAD: in_ready_c = !dest_full;
                ST_PARITY:  in_ready_c = !dest_full;
                default:    in_ready_c = 1'b1;
            endcase
        end
    end

    assign bus.in_ready = in_ready_c;
    assign accept       = bus.in_valid && in_ready_c;
    assign write_en     = accept && (state_q != ST_DROP) &&
                          !((state_q == ST_IDLE) && (hdr_a == DROP_ADDR));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        par_d        = par_q;
        parity_err_d = 1'b0;
        addr_err_d   = 1'b0;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    len_d = hdr_len(bus.in_data);
                    cnt_d = '0;
                    if (hdr_a == DROP_ADDR) begin
                        addr_err_d = 1'b1;
                        state_d    = ST_DROP;
                    end else begin
                        addr_d  = hdr_a;
                        par_d   = bus.in_data;
                        state_d = (hdr_len(bus.in_data) == '0) ? ST_PARITY : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    par_d = par_q ^ bus.in_data;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q + LEN_W'(1) == len_q) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    parity_err_d = (bus.in_data != par_q);
                    state_d      = ST_IDLE;
                end
                default: begin
                    // DROP swallows len payload bytes plus the parity byte.
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q) state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            par_q        <= '0;
            parity_err_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign bus.parity_err = parity_err_q;
    assign bus.addr_err   = addr_err_q;

    genvar gi;
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign push[gi]          = write_en && (dest == ADDR_W'(gi));
        assign pop[gi]           = bus.out_ready[gi] && !empty[gi];
        assign bus.out_valid[gi] = !empty[gi];

        router_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[gi]),
            .pop_i   (pop[gi]),
            .flush_i (flush[gi]),
            .din_i   (bus.in_data),
            .dout_o  (bus.out_data[gi*DATA_W +: DATA_W]),
            .full_o  (full[gi]),
            .empty_o (empty[gi])
        );
    end

`ifdef ROUTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [NUM_PORTS-1:0] tflush_q;

    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_timeout
        logic [TO_W-1:0] stall_q;
        assign flush[gi] = (stall_q == TO_W'(TIMEOUT));
        always_ff @(posedge clk) begin
            if (rst || flush[gi])
                stall_q <= '0;
            else if (bus.out_valid[gi] && !bus.out_ready[gi])
                stall_q <= stall_q + TO_W'(1);
            else
                stall_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) tflush_q <= '0;
        else     tflush_q <= flush;
    end
    assign bus.timeout_flush = tflush_q;
`else
    assign flush             = '0;
    assign bus.timeout_flush = '0;
`endif
endmodule

// File: tb/tb_router_1x3.sv
// Directed bench for router_1x3: packet-level reference model checked every cycle plus literal pins.
module tb_router_1x3;
    import router_pkg::*;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 30;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    router_if bus();

    router_1x3 #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // reference model: packet parser position and expected FIFO contents
    logic [7:0] mq [NUM_PORTS][$];
    bit         in_pkt = 0;
    bit         drop   = 0;
    int         remaining = 0;
    int         cur = 0;
    logic [7:0] xacc = 8'h00;
    bit         exp_perr = 0;
    bit         exp_aerr = 0;
    logic [2:0] exp_tflush = 3'b000;
    int         stall [NUM_PORTS];

    // observations for literal pins
    logic [7:0] log_q [NUM_PORTS][$];
    int         perr_cnt = 0;
    int         aerr_cnt = 0;
    int         tf_cnt [NUM_PORTS];
    bit         mon_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic       exp_rdy;
        logic [2:0] fl;
        logic [7:0] b;
        int         a;
        exp_rdy = 1'b0;
        if (!rst) begin
            if (drop)        exp_rdy = 1'b1;
            else if (in_pkt) exp_rdy = (mq[cur].size() < DEPTH);
            else begin
                a = int'(bus.in_data[1:0]);
                exp_rdy = (a == 3) ? 1'b1 : (mq[a].size() < DEPTH);
            end
        end
        chk("in_ready", bus.in_ready, exp_rdy);
        for (int i = 0; i < NUM_PORTS; i++) begin
            chk("out_valid", bus.out_valid[i], mq[i].size() != 0);
            if (mq[i].size() != 0) chk("out_data", bus.out_data[8*i +: 8], mq[i][0]);
            if (bus.out_valid[i] && bus.out_ready[i]) log_q[i].push_back(bus.out_data[8*i +: 8]);
            if (bus.timeout_flush[i]) tf_cnt[i]++;
        end
        chk("parity_err", bus.parity_err, exp_perr);
        chk("addr_err", bus.addr_err, exp_aerr);
        chk("timeout_flush", bus.timeout_flush, exp_tflush);
        if (bus.parity_err) perr_cnt++;
        if (bus.addr_err)   aerr_cnt++;

        exp_perr   = 0;
        exp_aerr   = 0;
        exp_tflush = 3'b000;
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                mq[i].delete();
                stall[i] = 0;
            end
            in_pkt = 0;
            drop   = 0;
            return;
        end
        fl = 3'b000;
        for (int i = 0; i < NUM_PORTS; i++) begin
`ifdef ROUTER_TIMEOUT_EN
            if (stall[i] == TIMEOUT) fl[i] = 1'b1;
`endif
            if (fl[i]) begin
                mq[i].delete();
                stall[i] = 0;
                exp_tflush[i] = 1'b1;
            end else begin
                stall[i] = (mq[i].size() != 0 && !bus.out_ready[i]) ? stall[i] + 1 : 0;
                if (bus.out_ready[i] && mq[i].size() != 0) void'(mq[i].pop_front());
            end
        end
        if (bus.in_valid && exp_rdy) begin
            b = bus.in_data;
            if (drop) begin
                remaining--;
                if (remaining == 0) drop = 0;
            end else if (in_pkt) begin
                if (!fl[cur]) mq[cur].push_back(b);
                remaining--;
                if (remaining == 0) begin
                    in_pkt   = 0;
                    exp_perr = (b != xacc);
                end else begin
                    xacc = xacc ^ b;
                end
            end else begin
                a = int'(b[1:0]);
                remaining = int'(b[7:2]) + 1;
                if (a == 3) begin
                    drop     = 1;
                    exp_aerr = 1;
                end else begin
                    in_pkt = 1;
                    cur    = a;
                    xacc   = b;
                    if (!fl[a]) mq[a].push_back(b);
                end
            end
        end
    endtask

    always @(negedge clk) if (mon_en) model_step();

    task automatic send_byte(input logic [7:0] b);
        int n;
        bit acc;
        n   = 0;
        acc = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n >= 500) begin
                chk("send_wait", acc, 1);
                break;
            end
        end
    endtask

    task automatic send_pkt(input bq_t p);
        $display("pkt hdr=%02h len=%0d port=%0d bytes=%0d", p[0], p[0][7:2], p[0][1:0], p.size());
        foreach (p[i]) send_byte(p[i]);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_log(input int port, input bq_t exp, input string name);
        chk({name, "_len"}, log_q[port].size(), exp.size());
        for (int i = 0; i < exp.size() && i < log_q[port].size(); i++)
            chk({name, "_byte"}, log_q[port][i], exp[i]);
    endtask

    task automatic clear_obs();
        for (int i = 0; i < NUM_PORTS; i++) begin
            log_q[i].delete();
            tf_cnt[i] = 0;
        end
        perr_cnt = 0;
        aerr_cnt = 0;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t p;
        bq_t e;
        for (int i = 0; i < NUM_PORTS; i++) stall[i] = 0;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 3'b111;
        @(posedge clk);
        #1;
        mon_en = 1;
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 3'b000);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_obs();

        // 1: well-formed packet to port 1 (0D^11^22^33 = 0D)
        p = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        send_pkt(p);
        idle(4);
        check_log(1, p, "t1_port1");
        chk("t1_perr_cnt", perr_cnt, 0);

        // 2: bad parity byte still delivered, one parity_err pulse
        clear_obs();
        p = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
        send_pkt(p);
        idle(4);
        check_log(1, p, "t2_port1");
        chk("t2_perr_cnt", perr_cnt, 1);

        // 3: addr 3 dropped, then a packet to port 0 (04^5A = 5E)
        clear_obs();
        p = '{8'h07, 8'hAA, 8'hBB};
        send_pkt(p);
        p = '{8'h04, 8'h5A, 8'h5E};
        send_pkt(p);
        idle(4);
        chk("t3_aerr_cnt", aerr_cnt, 1);
        check_log(0, p, "t3_port0");
        chk("t3_port1_len", log_q[1].size(), 0);
        chk("t3_port2_len", log_q[2].size(), 0);
        chk("t3_perr_cnt", perr_cnt, 0);

        // 4: 22-byte packet into stalled port 2 (parity 52 ^ (1^..^20) = 46)
        clear_obs();
        p = '{8'h52};
        for (int i = 1; i <= 20; i++) p.push_back(8'(i));
        p.push_back(8'h46);
        bus.out_ready = 3'b011;
        fork
            send_pkt(p);
            begin
                repeat (25) @(posedge clk);
                @(negedge clk);
                chk("t4_full_in_ready", bus.in_ready, 1'b0);
                chk("t4_full_valid", bus.out_valid[2], 1'b1);
                @(posedge clk);
                #1;
                bus.out_ready = 3'b111;
            end
        join
        idle(30);
        check_log(2, p, "t4_port2");
        chk("t4_perr_cnt", perr_cnt, 0);

        // 5: reset after two payload bytes of a len-5 packet to port 1
        clear_obs();
        bus.out_ready = 3'b000;
        $display("pkt hdr=15 len=5 port=1 bytes=3 (truncated by reset)");
        send_byte(8'h15);
        send_byte(8'h01);
        send_byte(8'h02);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t5_pre_rst_valid", bus.out_valid, 3'b010);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_post_rst_valid", bus.out_valid, 3'b000);
        @(posedge clk);
        #1;
        bus.out_ready = 3'b111;
        p = '{8'h04, 8'h77, 8'h73};
        send_pkt(p);
        idle(4);
        check_log(0, p, "t5_port0");
        chk("t5_port1_len", log_q[1].size(), 0);

`ifdef ROUTER_TIMEOUT_EN
        // 6: zero-length packet to port 0 held back until the stall timeout flushes it
        clear_obs();
        bus.out_ready = 3'b110;
        p = '{8'h00, 8'h00};
        send_pkt(p);
        idle(40);
        chk("t6_tflush_cnt", tf_cnt[0], 1);
        chk("t6_valid0", bus.out_valid[0], 1'b0);
        chk("t6_port0_len", log_q[0].size(), 0);
        bus.out_ready = 3'b111;
`endif

        idle(2);
        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
